// File: rtl/spram_pwr_ctrl.sv
// Single-port RAM with nibble write mask, registered read and a standby/sleep/off power controller.
// Optional per-nibble even parity (par_inject / par_err) is compiled in when SPRAM_PARITY_EN is defined.
module spram_pwr_ctrl #(
    parameter int unsigned DEPTH    = 16384,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned ADDRBITS = 14,
    parameter int unsigned WAKE_CYC = 4,
    parameter int unsigned IDLE_CYC = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDRBITS-1:0]  req_adr,
    input  logic [WIDTH-1:0]     req_d,
    input  logic [WIDTH/4-1:0]   req_wem,
    output logic                 rsp_valid,
    output logic [WIDTH-1:0]     rsp_q,
    input  logic [1:0]           pwr_req,
    output logic [1:0]           pwr_state,
    output logic                 busy,
    output logic                 data_lost,
    output logic                 oor
`ifdef SPRAM_PARITY_EN
    ,
    input  logic                 par_inject,
    output logic                 par_err
`endif
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WCW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
    localparam int unsigned ICW = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;

    // Low two bits are the reported mode; bit 2 marks WAKE so busy falls out directly.
    typedef enum logic [2:0] {
        ST_ACTIVE  = 3'b000,
        ST_STANDBY = 3'b001,
        ST_SLEEP   = 3'b010,
        ST_OFF     = 3'b011,
        ST_WAKE    = 3'b101
    } state_t;

    state_t             state_q;
    logic [ICW-1:0]     idle_q;
    logic [WCW-1:0]     wake_q;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic               accept;
    logic               in_range;
    logic [IW-1:0]      idx;

    assign in_range  = 32'(req_adr) < DEPTH;
    assign idx       = IW'(req_adr);
    assign req_ready = !RST && (state_q == ST_ACTIVE) && (pwr_req == 2'b00);
    assign accept    = req_valid && req_ready;
    assign pwr_state = state_q[1:0];
    assign busy      = state_q[2];

`ifdef SPRAM_PARITY_EN
    logic [NIB-1:0] par_mem [DEPTH];

    function automatic logic [NIB-1:0] nib_par(input logic [WIDTH-1:0] w);
        logic [NIB-1:0] p;
        p = '0;
        for (int n = 0; n < NIB; n++) p[n] = ^w[4*n +: 4];
        return p;
    endfunction
`endif

    // Storage: only enabled nibbles of in-range accepted writes are updated.
    always_ff @(posedge CLK) begin
        if (accept && req_we && in_range) begin
            for (int n = 0; n < NIB; n++) begin
                if (req_wem[n]) begin
                    mem[idx][4*n +: 4] <= req_d[4*n +: 4];
`ifdef SPRAM_PARITY_EN
                    par_mem[idx][n] <= (^req_d[4*n +: 4]) ^ par_inject;
`endif
                end
            end
        end
    end

    // Power FSM, idle/wake counters and registered response path.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_ACTIVE;
            idle_q    <= '0;
            wake_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            oor       <= 1'b0;
            data_lost <= 1'b0;
`ifdef SPRAM_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            rsp_valid <= accept && !req_we;
            oor       <= accept && !in_range;
            if (accept && !req_we) rsp_q <= in_range ? mem[idx] : '0;
            if (accept && req_we && in_range) data_lost <= 1'b0;
`ifdef SPRAM_PARITY_EN
            par_err <= accept && !req_we && in_range && (par_mem[idx] != nib_par(mem[idx]));
`endif
            case (state_q)
                ST_ACTIVE: begin
                    if (pwr_req != 2'b00) begin
                        idle_q <= '0;
                        case (pwr_req)
                            2'b01:   state_q <= ST_STANDBY;
                            2'b10:   state_q <= ST_SLEEP;
                            default: begin
                                state_q   <= ST_OFF;
                                data_lost <= 1'b1;
                            end
                        endcase
                    end else if (accept || IDLE_CYC == 0) begin
                        idle_q <= '0;
                    end else if (idle_q == ICW'(IDLE_CYC - 1)) begin
                        state_q <= ST_STANDBY;
                        idle_q  <= '0;
                    end else begin
                        idle_q <= idle_q + ICW'(1);
                    end
                end
                ST_STANDBY: begin
                    case (pwr_req)
                        2'b00:   state_q <= ST_ACTIVE;
                        2'b10:   state_q <= ST_SLEEP;
                        2'b11: begin
                            state_q   <= ST_OFF;
                            data_lost <= 1'b1;
                        end
                        default: state_q <= ST_STANDBY;
                    endcase
                end
                ST_SLEEP: begin
                    if (pwr_req == 2'b00) begin
                        state_q <= ST_WAKE;
                        wake_q  <= '0;
                    end else if (pwr_req == 2'b11) begin
                        state_q   <= ST_OFF;
                        data_lost <= 1'b1;
                    end
                end
                ST_OFF: begin
                    if (pwr_req == 2'b00) begin
                        state_q <= ST_WAKE;
                        wake_q  <= '0;
                    end
                end
                ST_WAKE: begin
                    if (wake_q == WCW'(WAKE_CYC - 1)) begin
                        state_q <= ST_ACTIVE;
                        wake_q  <= '0;
                    end else begin
                        wake_q <= wake_q + WCW'(1);
                    end
                end
                default: state_q <= ST_ACTIVE;
            endcase
        end
    end

endmodule

// File: tb/tb_spram_pwr_ctrl.sv
// Randomized bench for spram_pwr_ctrl (DEPTH=1000) against a transaction-level power/memory model.
module tb_spram_pwr_ctrl;

    localparam int unsigned DEPTH    = 1000;
    localparam int unsigned WIDTH    = 16;
    localparam int unsigned ADDRBITS = 14;
    localparam int unsigned WAKE_CYC = 4;
    localparam int unsigned IDLE_CYC = 8;

    localparam int M_ACT  = 0;
    localparam int M_STBY = 1;
    localparam int M_SLP  = 2;
    localparam int M_OFF  = 3;
    localparam int M_WAKE = 4;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic                req_we = 1'b0;
    logic [ADDRBITS-1:0] req_adr = '0;
    logic [WIDTH-1:0]    req_d = '0;
    logic [WIDTH/4-1:0]  req_wem = '0;
    logic                rsp_valid;
    logic [WIDTH-1:0]    rsp_q;
    logic [1:0]          pwr_req = 2'b00;
    logic [1:0]          pwr_state;
    logic                busy;
    logic                data_lost;
    logic                oor;

    spram_pwr_ctrl #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .ADDRBITS(ADDRBITS),
        .WAKE_CYC(WAKE_CYC), .IDLE_CYC(IDLE_CYC)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_d(req_d), .req_wem(req_wem),
        .rsp_valid(rsp_valid), .rsp_q(rsp_q),
        .pwr_req(pwr_req), .pwr_state(pwr_state), .busy(busy),
        .data_lost(data_lost), .oor(oor)
    );

    always #5 CLK = ~CLK;

    // Reference model: mode, wait counts, memory image and expected response registers.
    int          m_mode, m_wake, m_idle;
    bit          m_lost;
    logic [15:0] m_mem [DEPTH];
    bit          e_rv, e_oor, e_q_dc;
    logic [15:0] e_q;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_mode = M_ACT; m_wake = 0; m_idle = 0; m_lost = 1'b0;
        e_rv = 1'b0; e_oor = 1'b0; e_q = '0; e_q_dc = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic we, input int adr,
                              input logic [15:0] d, input logic [3:0] wem, input int pwr);
        bit          acc, inr;
        logic [15:0] mask;
        acc = (m_mode == M_ACT) && (pwr == 0) && v;
        inr = adr < int'(DEPTH);
        e_rv  = acc && !we;
        e_oor = acc && !inr;
        if (acc && !we) begin
            e_q    = inr ? m_mem[adr] : 16'h0000;
            e_q_dc = inr && m_lost;
        end
        if (acc && we && inr) begin
            mask = {{4{wem[3]}}, {4{wem[2]}}, {4{wem[1]}}, {4{wem[0]}}};
            m_mem[adr] = (m_mem[adr] & ~mask) | (d & mask);
            m_lost = 1'b0;
        end
        case (m_mode)
            M_ACT: begin
                if (pwr != 0) begin
                    m_mode = pwr;
                    m_idle = 0;
                    if (pwr == 3) m_lost = 1'b1;
                end else if (acc) m_idle = 0;
                else if (IDLE_CYC != 0) begin
                    m_idle++;
                    if (m_idle == int'(IDLE_CYC)) begin m_mode = M_STBY; m_idle = 0; end
                end
            end
            M_STBY: begin
                if (pwr == 0) m_mode = M_ACT;
                else if (pwr == 2) m_mode = M_SLP;
                else if (pwr == 3) begin m_mode = M_OFF; m_lost = 1'b1; end
            end
            M_SLP: begin
                if (pwr == 0) begin m_mode = M_WAKE; m_wake = 0; end
                else if (pwr == 3) begin m_mode = M_OFF; m_lost = 1'b1; end
            end
            M_OFF: if (pwr == 0) begin m_mode = M_WAKE; m_wake = 0; end
            default: begin
                m_wake++;
                if (m_wake == int'(WAKE_CYC)) m_mode = M_ACT;
            end
        endcase
    endtask

    task automatic check_outputs();
        logic exp_rdy;
        exp_rdy = !RST && (m_mode == M_ACT) && (pwr_req == 2'b00);
        check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
        check_val("pwr_state", 32'(pwr_state), (m_mode == M_WAKE) ? 32'd1 : 32'(m_mode));
        check_val("busy", 32'(busy), 32'(m_mode == M_WAKE));
        check_val("data_lost", 32'(data_lost), 32'(m_lost));
        check_val("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        check_val("oor", 32'(oor), 32'(e_oor));
        if (!e_q_dc) check_val("rsp_q", 32'(rsp_q), 32'(e_q));
    endtask

    // One clock: drive after the falling edge, check, advance the model, cross the rising edge.
    task automatic cycle(input logic v, input logic we, input logic [13:0] adr,
                         input logic [15:0] d, input logic [3:0] wem, input logic [1:0] pwr);
        req_valid = v; req_we = we; req_adr = adr; req_d = d; req_wem = wem; pwr_req = pwr;
        #1;
        check_outputs();
        model_step(v, we, int'(adr), d, wem, int'(pwr));
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle(input int n, input logic [1:0] pwr);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 14'h0, 16'h0, 4'h0, pwr);
    endtask

    task automatic apply_reset();
        req_valid = 1'b0; pwr_req = 2'b00;
        #1;
        check_outputs();
        #1;
        RST = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        int          nb;
        int          vprob;
        logic [1:0]  pw;
        logic [13:0] ra;

        model_reset();
        #2;
        check_outputs();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        for (int a = 0; a < int'(DEPTH); a++)
            cycle(1'b1, 1'b1, 14'(a), 16'($urandom), 4'hF, 2'b00);

        // Nibble-masked overwrite then read
        cycle(1'b1, 1'b1, 14'h0010, 16'hABCD, 4'b1111, 2'b00);
        cycle(1'b1, 1'b1, 14'h0010, 16'h1234, 4'b0010, 2'b00);
        cycle(1'b1, 1'b0, 14'h0010, 16'h0000, 4'b0000, 2'b00);
        check_val("masked_read", 32'(rsp_q), 32'h0000AB3D);
        cycle(1'b1, 1'b1, 14'h0011, 16'h1234, 4'b0101, 2'b00);
        cycle(1'b1, 1'b0, 14'h0011, 16'h0000, 4'b0000, 2'b00);

        // Sleep then wake: four busy cycles
        idle(5, 2'b10);
        check_val("sleep_state", 32'(pwr_state), 32'd2);
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 14'h0, 16'h0, 4'h0, 2'b00);
            if (busy) nb++;
        end
        check_val("wake_cycles", 32'(nb), 32'(WAKE_CYC));
        cycle(1'b1, 1'b0, 14'h0010, 16'h0000, 4'b0000, 2'b00);
        check_val("sleep_retain", 32'(rsp_q), 32'h0000AB3D);

        // Off / data_lost
        cycle(1'b1, 1'b1, 14'h0003, 16'h5A5A, 4'hF, 2'b00);
        idle(3, 2'b11);
        idle(6, 2'b00);
        check_val("lost_after_off", 32'(data_lost), 32'd1);
        cycle(1'b1, 1'b1, 14'h0003, 16'hFFFF, 4'h0, 2'b00);
        check_val("lost_cleared", 32'(data_lost), 32'd0);
        cycle(1'b1, 1'b0, 14'h0003, 16'h0000, 4'h0, 2'b00);
        check_val("off_retain", 32'(rsp_q), 32'h00005A5A);

        // Idle auto-standby and wake-by-request
        idle(8, 2'b00);
        check_val("auto_standby", 32'(pwr_state), 32'd1);
        cycle(1'b1, 1'b0, 14'h0010, 16'h0, 4'h0, 2'b00);
        cycle(1'b1, 1'b0, 14'h0010, 16'h0, 4'h0, 2'b00);
        check_val("standby_rsp", 32'(rsp_valid), 32'd1);
        idle(1, 2'b00);

        // Out of range: no aliasing onto low addresses
        cycle(1'b1, 1'b0, 14'd1000, 16'h0, 4'h0, 2'b00);
        check_val("oor_rsp_q", 32'(rsp_q), 32'd0);
        check_val("oor_pulse", 32'(oor), 32'd1);
        for (int a = 1000; a < 1024; a++) cycle(1'b1, 1'b1, 14'(a), 16'hFFFF, 4'hF, 2'b00);
        for (int a = 1000; a < 1024; a++) cycle(1'b1, 1'b0, 14'(a), 16'h0, 4'h0, 2'b00);
        for (int a = 0; a < 24; a++)      cycle(1'b1, 1'b0, 14'(a), 16'h0, 4'h0, 2'b00);
        cycle(1'b1, 1'b0, 14'h3FFF, 16'h0, 4'h0, 2'b00);

        // Reset mid-wake and mid-read
        idle(3, 2'b10);
        idle(2, 2'b00);
        apply_reset();
        cycle(1'b1, 1'b0, 14'h0010, 16'h0, 4'h0, 2'b00);
        cycle(1'b1, 1'b0, 14'h0003, 16'h0, 4'h0, 2'b00);
        apply_reset();
        cycle(1'b1, 1'b0, 14'h0003, 16'h0, 4'h0, 2'b00);
        idle(1, 2'b00);

        // Random traffic with random power requests
        pw = 2'b00;
        vprob = 60;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0)
                pw = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 63) == 0) vprob = int'($urandom_range(0, 100));
            ra = ($urandom_range(0, 15) == 0) ? 14'($urandom) : 14'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 499) == 0) apply_reset();
            else cycle(int'($urandom_range(0, 99)) < vprob, 1'($urandom_range(0, 1)), ra,
                       16'($urandom), 4'($urandom), pw);
        end
        idle(1, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
